stream_sum_n: RTL and testbench

//   N-channel streaming adder; parametrised successor of the two-input adder stage.
//   - Joins N_CH valid/ready input streams and emits one full-width sum beat per joined set.
//   - Propagates a frame 'last' flag; flags channels whose frame boundaries disagree.
//   - 2-entry output buffer decouples in_ready from out_ready (no combinational ready path).
//   - Sits between the per-channel data sources and downstream accumulate/pack stages.

---
 rtl/stream_pkg.sv | 31 +++
 rtl/stream_skid2.sv | 102 ++++++++++
 rtl/stream_sum_n.sv | 104 ++++++++++
 tb/tb_stream_sum_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// stream_pkg
//   Shared definitions for the streaming-sum datapath.
//   - sum_width(): output width that can hold the sum of n_ch values of len bits
//     without overflow.
//   - Default channel count, input width and the output width derived from them.
//   - fill_t: occupancy of the 2-entry output buffer.
//   - beat_t: {last, data} beat at the default widths, used by downstream stages.
package stream_pkg;

  // Output width for an overflow-free sum of n_ch operands of len bits.
  function automatic int sum_width(input int len, input int n_ch);
    return len + $clog2(n_ch);
  endfunction

  localparam int N_CH_DEFAULT  = 4;
  localparam int LEN_DEFAULT   = 8;
  localparam int OUT_W_DEFAULT = sum_width(LEN_DEFAULT, N_CH_DEFAULT);

  // Buffer occupancy doubles as the buffer state; the encoding is the entry count.
  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_FULL  = 2'd2
  } fill_t;

  typedef struct packed {
    logic                     last;
    logic [OUT_W_DEFAULT-1:0] data;
  } beat_t;

endpackage

// File: rtl/stream_skid2.sv
// stream_skid2
//   Generic 2-entry valid/ready buffer, FIFO order.
//   in_ready is derived only from the registered occupancy, so there is no
//   combinational path from out_ready to in_ready. The head entry drives
//   out_data directly and holds its value while the buffer is empty.
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset, empties the buffer
//   in_data    in   WIDTH   beat to store
//   in_valid   in   1       in_data is offered
//   in_ready   out  1       buffer has a free entry (occupancy < 2)
//   out_data   out  WIDTH   head entry
//   out_valid  out  1       buffer is not empty
//   out_ready  in   1       downstream takes the head entry
module stream_skid2
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  fill_t            state;
  fill_t            state_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_next;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_next;
  logic             push;
  logic             pop;

  // When full, a push is refused even if a pop happens in the same cycle;
  // this keeps in_ready independent of out_ready.
  assign in_ready  = (state != FILL_FULL);
  assign out_valid = (state != FILL_EMPTY);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next occupancy and entry contents; the tail only ever feeds the head.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    case (state)
      FILL_EMPTY: begin
        if (push) begin
          head_next  = in_data;
          state_next = FILL_ONE;
        end else begin
          state_next = FILL_EMPTY;
        end
      end
      FILL_ONE: begin
        if (push && pop) begin
          // Pass-through: new beat replaces the departing head.
          head_next  = in_data;
          state_next = FILL_ONE;
        end else if (push) begin
          tail_next  = in_data;
          state_next = FILL_FULL;
        end else if (pop) begin
          state_next = FILL_EMPTY;
        end else begin
          state_next = FILL_ONE;
        end
      end
      FILL_FULL: begin
        if (pop) begin
          head_next  = tail;
          state_next = FILL_ONE;
        end else begin
          state_next = FILL_FULL;
        end
      end
      default: begin
        state_next = FILL_EMPTY;
      end
    endcase
  end

  // Occupancy and entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

endmodule

// File: rtl/stream_sum_n.sv
// stream_sum_n
//   N-channel streaming adder. All N_CH input streams are joined: they transfer
//   together in one cycle or not at all. Each joined set produces one full-width
//   sum beat carrying the AND of the channels' last flags. A sticky flag records
//   any joined set whose last flags disagreed. A 2-entry buffer decouples
//   in_ready from out_ready.
// Parameters
//   N_CH    number of input channels (>= 2)
//   LEN     data width per channel
//   SIGNED  1: channels are two's complement and sign-extended; 0: zero-extended
//   OUT_W   output width, wide enough that the sum never overflows
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   in_data    in   N_CH*LEN    channel i at [i*LEN +: LEN]
//   in_valid   in   N_CH        per-channel valid
//   in_last    in   N_CH        per-channel end-of-frame
//   in_ready   out  N_CH        per-channel ready (all bits equal)
//   out_data   out  OUT_W       sum of the joined beat
//   out_valid  out  1           output beat available
//   out_last   out  1           AND of the joined in_last bits
//   out_ready  in   1           downstream ready
//   last_err   out  1           sticky: some joined beat had mixed in_last bits
module stream_sum_n
  import stream_pkg::*;
#(
  parameter int N_CH   = N_CH_DEFAULT,
  parameter int LEN    = LEN_DEFAULT,
  parameter int SIGNED = 0,
  parameter int OUT_W  = sum_width(LEN, N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*LEN-1:0] in_data,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH-1:0]     in_last,
  output logic [N_CH-1:0]     in_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic                last_err
);

  logic [LEN-1:0]   chan;
  logic [OUT_W-1:0] chan_ext;
  logic [OUT_W-1:0] sum;
  logic             buf_ready;
  logic             fire;
  logic             join_last;
  logic             mixed_last;
  logic [OUT_W:0]   buf_out;

  // Extend every channel to OUT_W and add; OUT_W leaves room for the carries.
  always_comb begin
    chan     = '0;
    chan_ext = '0;
    sum      = '0;
    for (int i = 0; i < N_CH; i++) begin
      chan = in_data[i*LEN +: LEN];
      if (SIGNED != 0) begin
        chan_ext = {{(OUT_W-LEN){chan[LEN-1]}}, chan};
      end else begin
        chan_ext = {{(OUT_W-LEN){1'b0}}, chan};
      end
      sum = sum + chan_ext;
    end
  end

  // Join: every channel must be valid and the buffer must have room. Holding
  // fire low during reset keeps in_ready low in the reset cycles.
  assign fire       = (&in_valid) && buf_ready && !rst;
  assign in_ready   = {N_CH{fire}};
  assign join_last  = &in_last;
  assign mixed_last = (|in_last) && !(&in_last);

  stream_skid2 #(
    .WIDTH (OUT_W + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({join_last, sum}),
    .in_valid  (fire),
    .in_ready  (buf_ready),
    .out_data  (buf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_last = buf_out[OUT_W];
  assign out_data = buf_out[OUT_W-1:0];

  // Sticky frame-boundary disagreement flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_err <= 1'b0;
    end else if (fire && mixed_last) begin
      last_err <= 1'b1;
    end else begin
      last_err <= last_err;
    end
  end

endmodule

// File: tb/tb_stream_sum_n.sv
// tb_stream_sum_n
//   Directed bench for stream_sum_n. Two instances share the same stimulus:
//   one unsigned (dut_u) and one signed (dut_s), both N_CH=4, LEN=8, OUT_W=10.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_stream_sum_n;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  in_ready_u;
  logic [9:0]  out_data_u;
  logic        out_valid_u;
  logic        out_last_u;
  logic        last_err_u;

  logic [3:0]  in_ready_s;
  logic [9:0]  out_data_s;
  logic        out_valid_s;
  logic        out_last_s;
  logic        last_err_s;

  int n_cmp;
  int n_err;

  stream_sum_n #(.N_CH(4), .LEN(8), .SIGNED(0)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_u),
    .out_data  (out_data_u),
    .out_valid (out_valid_u),
    .out_last  (out_last_u),
    .out_ready (out_ready),
    .last_err  (last_err_u)
  );

  stream_sum_n #(.N_CH(4), .LEN(8), .SIGNED(1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_s),
    .out_data  (out_data_s),
    .out_valid (out_valid_s),
    .out_last  (out_last_s),
    .out_ready (out_ready),
    .last_err  (last_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] c0, input logic [7:0] c1,
                                        input logic [7:0] c2, input logic [7:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Offer one joined beat with out_ready=1 and check the following cycle.
  task automatic one_beat(input string tag, input logic [31:0] data,
                          input logic [9:0] exp_u, input logic [9:0] exp_s);
    in_data  = data;
    in_valid = 4'hF;
    settle();
    chk({tag, "_in_ready"}, {28'd0, in_ready_u}, 32'h0000_000F);
    tick();
    in_valid = 4'h0;
    chk({tag, "_valid_u"}, {31'd0, out_valid_u}, 32'd1);
    chk({tag, "_data_u"}, {22'd0, out_data_u}, {22'd0, exp_u});
    chk({tag, "_valid_s"}, {31'd0, out_valid_s}, 32'd1);
    chk({tag, "_data_s"}, {22'd0, out_data_s}, {22'd0, exp_s});
    tick();
    chk({tag, "_drained"}, {31'd0, out_valid_u}, 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_data   = pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    in_valid  = 4'hF;
    in_last   = 4'h0;
    out_ready = 1'b1;

    // Reset held 3 cycles with every channel valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready_u", {28'd0, in_ready_u}, 32'd0);
      chk("rst_in_ready_s", {28'd0, in_ready_s}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
      chk("rst_last_err", {31'd0, last_err_u}, 32'd0);
    end
    chk("rst_out_data", {22'd0, out_data_u}, 32'd0);
    chk("rst_out_last", {31'd0, out_last_u}, 32'd0);

    rst      = 1'b0;
    in_valid = 4'h0;
    tick();
    chk("post_rst_out_valid", {31'd0, out_valid_u}, 32'd0);

    // Basic: 4 x 255 = 1020; signed view is 4 x -1 = -4, same 10-bit pattern.
    one_beat("basic", pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 10'h3FC, 10'h3FC);
    // 4 x 0x80: unsigned 512, signed -512, both 10'h200.
    one_beat("min_neg", pack4(8'h80, 8'h80, 8'h80, 8'h80), 10'h200, 10'h200);
    // {255,0,0,0}: unsigned 255, signed -1.
    one_beat("one_neg", pack4(8'hFF, 8'h00, 8'h00, 8'h00), 10'h0FF, 10'h3FF);
    // {127,128,1,255}: unsigned 511, signed 127-128+1-1 = -1.
    one_beat("mixed", pack4(8'h7F, 8'h80, 8'h01, 8'hFF), 10'h1FF, 10'h3FF);

    // Partial valid: channel 3 missing for 5 cycles.
    in_data  = pack4(8'd1, 8'd2, 8'd3, 8'd4);
    in_valid = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("partial_in_ready", {28'd0, in_ready_u}, 32'd0);
      tick();
      chk("partial_out_valid", {31'd0, out_valid_u}, 32'd0);
    end
    one_beat("partial_join", pack4(8'd1, 8'd2, 8'd3, 8'd4), 10'd10, 10'd10);

    // Backpressure: beats sum to 4, 8, 12, 16.
    out_ready = 1'b0;
    in_data   = pack4(8'd1, 8'd1, 8'd1, 8'd1);
    in_valid  = 4'hF;
    settle();
    chk("bp_a_ready", {28'd0, in_ready_u}, 32'h0000_000F);
    tick();
    in_data = pack4(8'd2, 8'd2, 8'd2, 8'd2);
    settle();
    chk("bp_b_ready", {28'd0, in_ready_u}, 32'h0000_000F);
    tick();
    in_data = pack4(8'd3, 8'd3, 8'd3, 8'd3);
    settle();
    chk("bp_c_blocked", {28'd0, in_ready_u}, 32'd0);
    tick();
    chk("bp_c_still_blocked", {28'd0, in_ready_u}, 32'd0);
    chk("bp_hold_valid", {31'd0, out_valid_u}, 32'd1);
    chk("bp_hold_data", {22'd0, out_data_u}, 32'd4);
    out_ready = 1'b1;
    settle();
    chk("bp_release_no_comb_ready", {28'd0, in_ready_u}, 32'd0);
    tick();
    chk("bp_out_b", {22'd0, out_data_u}, 32'd8);
    chk("bp_c_ready", {28'd0, in_ready_u}, 32'h0000_000F);
    tick();
    chk("bp_out_c", {22'd0, out_data_u}, 32'd12);
    in_data = pack4(8'd4, 8'd4, 8'd4, 8'd4);
    tick();
    chk("bp_out_d", {22'd0, out_data_u}, 32'd16);
    chk("bp_out_d_valid", {31'd0, out_valid_u}, 32'd1);
    in_valid = 4'h0;
    tick();
    chk("bp_drained", {31'd0, out_valid_u}, 32'd0);

    // Frame last handling.
    in_data  = pack4(8'd5, 8'd5, 8'd5, 8'd5);
    in_valid = 4'hF;
    in_last  = 4'b1111;
    tick();
    in_valid = 4'h0;
    chk("last_all_out_last", {31'd0, out_last_u}, 32'd1);
    chk("last_all_err", {31'd0, last_err_u}, 32'd0);
    in_valid = 4'hF;
    in_last  = 4'b0101;
    tick();
    in_valid = 4'h0;
    chk("last_mixed_out_last", {31'd0, out_last_u}, 32'd0);
    chk("last_mixed_err_u", {31'd0, last_err_u}, 32'd1);
    chk("last_mixed_err_s", {31'd0, last_err_s}, 32'd1);
    in_valid = 4'hF;
    in_last  = 4'b0000;
    tick();
    in_valid = 4'h0;
    chk("last_none_out_last", {31'd0, out_last_u}, 32'd0);
    chk("last_err_sticky", {31'd0, last_err_u}, 32'd1);
    tick();

    // Reset mid-stream drops the buffered beat and clears last_err.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    tick();
    chk("mid_buffered", {31'd0, out_valid_u}, 32'd1);
    rst = 1'b1;
    settle();
    chk("mid_rst_in_ready", {28'd0, in_ready_u}, 32'd0);
    tick();
    chk("mid_rst_out_valid", {31'd0, out_valid_u}, 32'd0);
    chk("mid_rst_last_err", {31'd0, last_err_u}, 32'd0);
    rst      = 1'b0;
    in_valid = 4'h0;
    tick();
    chk("mid_after_out_valid", {31'd0, out_valid_u}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
